// File: rtl/vie_mem_stage_pkg.sv
/*
 * +--------------------------------------------------------------------+
 * | vie_mem_stage_pkg                                                  |
 * | Bus widths, load opcodes and bus field helpers for the MEM stage.  |
 * | Revision: 1.0                                                      |
 * +--------------------------------------------------------------------+
 */
`default_nettype none

package vie_mem_stage_pkg;

    localparam int Vesbus    = 127;
    localparam int Vmsbus    = 95;
    localparam int Vmsfwd    = 38;
    localparam int Vflushbus = 33;

    localparam logic [7:0] VIE_OP_LB   = 8'h20;
    localparam logic [7:0] VIE_OP_LH   = 8'h21;
    localparam logic [7:0] VIE_OP_LWL  = 8'h22;
    localparam logic [7:0] VIE_OP_LW   = 8'h23;
    localparam logic [7:0] VIE_OP_LBU  = 8'h24;
    localparam logic [7:0] VIE_OP_LHU  = 8'h25;
    localparam logic [7:0] VIE_OP_LWR  = 8'h26;
    localparam logic [7:0] VIE_OP_MFC0 = 8'h40;
    localparam logic [7:0] VIE_OP_MTC0 = 8'h41;
    localparam logic [7:0] VIE_OP_ERET = 8'h42;

    typedef struct packed {
        logic        valid;
        logic        bd;
        logic [7:0]  op;
        logic [7:0]  cp0_addr;
        logic [5:0]  exc;
        logic [6:0]  dest;
        logic [31:0] pc;
        logic [31:0] rt_value;
        logic [31:0] res;
    } esbus_t;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vie_load_align.sv
/*
 * +--------------------------------------------------------------------+
 * | vie_load_align                                                     |
 * | Combinational load data alignment, extension and LWL/LWR merge.    |
 * | Revision: 1.0                                                      |
 * +--------------------------------------------------------------------+
 */
`default_nettype none

module vie_load_align
    import vie_mem_stage_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] ld_word_i,
    input  logic [31:0] rt_value_i,
    output logic [31:0] result_o,
    output logic        is_load_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = ld_word_i[{addr_i, 3'b000} +: 8];
        w_half    = addr_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        result_o  = ld_word_i;
        is_load_o = 1'b1;
        case (op_i)
            VIE_OP_LB:  result_o = ext8(w_byte, 1'b1);
            VIE_OP_LBU: result_o = ext8(w_byte, 1'b0);
            VIE_OP_LH:  result_o = ext16(w_half, 1'b1);
            VIE_OP_LHU: result_o = ext16(w_half, 1'b0);
            VIE_OP_LW:  result_o = ld_word_i;
            // Little-endian unaligned word merges with the old register value.
            VIE_OP_LWL: begin
                case (addr_i)
                    2'd0:    result_o = {ld_word_i[7:0],  rt_value_i[23:0]};
                    2'd1:    result_o = {ld_word_i[15:0], rt_value_i[15:0]};
                    2'd2:    result_o = {ld_word_i[23:0], rt_value_i[7:0]};
                    default: result_o = ld_word_i;
                endcase
            end
            VIE_OP_LWR: begin
                case (addr_i)
                    2'd0:    result_o = ld_word_i;
                    2'd1:    result_o = {rt_value_i[31:24], ld_word_i[31:8]};
                    2'd2:    result_o = {rt_value_i[31:16], ld_word_i[31:16]};
                    default: result_o = {rt_value_i[31:8],  ld_word_i[31:24]};
                endcase
            end
            default: is_load_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/vie_mem_stage.sv
/*
 * +--------------------------------------------------------------------+
 * | vie_mem_stage                                                      |
 * | MEM pipeline stage: load alignment, WB bus, forwarding to decode.  |
 * | Revision: 1.0                                                      |
 * +--------------------------------------------------------------------+
 */
`default_nettype none

module vie_mem_stage
    import vie_mem_stage_pkg::*;
#(
    parameter bit HOLD_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [Vesbus-1:0]    esbus_i,
    input  logic                 ws_allowin,
    input  logic [Vflushbus-1:0] flushbus_i,
    input  logic [31:0]          data_sram_rdata,
    output logic                 ms_allowin,
    output logic [Vmsbus-1:0]    msbus_o,
    output logic [Vmsfwd-1:0]    msfwd_o
);

    esbus_t      w_es;
    esbus_t      esbus_q;
    logic        ms_valid_q, ms_valid_d;
    logic        rdata_fresh_q;
    logic        w_flush;
    logic        w_transfer;
    logic        w_cango;
    logic [31:0] w_ld_word;
    logic [31:0] w_align;
    logic        w_is_load;
    logic [31:0] w_res;
    logic        w_fwd_we;
    logic        w_unused_bits;

    assign w_es          = esbus_t'(esbus_i);
    assign w_flush       = flushbus_i[32];
    assign w_cango       = 1'b1;
    assign ms_allowin    = !ms_valid_q || (ws_allowin && w_cango);
    assign w_transfer    = w_es.valid && ms_allowin;
    assign w_unused_bits = ^{flushbus_i[31:0], esbus_q.valid};

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (ms_allowin) begin
            ms_valid_d = w_es.valid && !w_flush;
        end else if (w_flush) begin
            ms_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ms_valid_q    <= 1'b0;
            rdata_fresh_q <= 1'b0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            rdata_fresh_q <= w_transfer;
        end
    end

    always_ff @(posedge clock) begin
        if (w_transfer) begin
            esbus_q <= w_es;
        end
    end

    generate
        if (HOLD_EN) begin : g_hold
            logic [31:0] hold_q;
            logic        hold_vld_q, hold_vld_d;
            logic        w_capture;

            // The SRAM only presents data for one cycle; keep it while WB stalls us.
            assign w_capture = rdata_fresh_q && !ws_allowin;

            always_comb begin
                hold_vld_d = hold_vld_q;
                if (w_flush || w_transfer) begin
                    hold_vld_d = 1'b0;
                end else if (w_capture) begin
                    hold_vld_d = 1'b1;
                end
            end

            always_ff @(posedge clock) begin
                if (!reset) begin
                    hold_vld_q <= 1'b0;
                end else begin
                    hold_vld_q <= hold_vld_d;
                end
            end

            always_ff @(posedge clock) begin
                if (w_capture) begin
                    hold_q <= data_sram_rdata;
                end
            end

            assign w_ld_word = (!rdata_fresh_q && hold_vld_q) ? hold_q : data_sram_rdata;
        end else begin : g_no_hold
            logic w_unused_fresh;
            assign w_unused_fresh = rdata_fresh_q;
            assign w_ld_word      = data_sram_rdata;
        end
    endgenerate

    vie_load_align u_load_align (
        .op_i       (esbus_q.op),
        .addr_i     (esbus_q.res[1:0]),
        .ld_word_i  (w_ld_word),
        .rt_value_i (esbus_q.rt_value),
        .result_o   (w_align),
        .is_load_o  (w_is_load)
    );

    // A faulting access keeps the raw address so WB can report it as BadVAddr.
    assign w_res = (w_is_load && (esbus_q.exc == 6'd0)) ? w_align : esbus_q.res;

    assign msbus_o = {ms_valid_q && w_cango && !w_flush,
                      esbus_q.bd, esbus_q.op, esbus_q.cp0_addr, esbus_q.exc,
                      esbus_q.dest, esbus_q.pc, w_res};

    assign w_fwd_we = ms_valid_q && (esbus_q.dest[6:5] == 2'b00) && (esbus_q.exc == 6'd0);
    assign msfwd_o  = {w_fwd_we, esbus_q.dest[4:0], w_res};

endmodule

`default_nettype wire

// File: tb/tb_vie_mem_stage.sv
/*
 * +--------------------------------------------------------------------+
 * | tb_vie_mem_stage                                                   |
 * | Directed self-checking bench for the MEM stage.                    |
 * | Revision: 1.0                                                      |
 * +--------------------------------------------------------------------+
 */
`default_nettype none

module tb_vie_mem_stage;

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LWL = 8'h22;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_LWR = 8'h26;
    localparam logic [7:0] OP_ADD = 8'h01;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [126:0] es;
    logic         ws_allowin;
    logic [32:0]  flushbus;
    logic [31:0]  rdata;
    logic         ms_allowin;
    logic [94:0]  msbus;
    logic [37:0]  msfwd;

    int n_checks = 0;
    int n_pass   = 0;

    vie_mem_stage #(.HOLD_EN(1'b1)) dut (
        .clock           (clk),
        .reset           (rst_n),
        .esbus_i         (es),
        .ws_allowin      (ws_allowin),
        .flushbus_i      (flushbus),
        .data_sram_rdata (rdata),
        .ms_allowin      (ms_allowin),
        .msbus_o         (msbus),
        .msfwd_o         (msfwd)
    );

    always #5 clk = ~clk;

    function automatic logic [126:0] mk_es(input logic v, input logic [7:0] op,
                                           input logic [5:0] exc, input logic [6:0] dest,
                                           input logic [31:0] rt, input logic [31:0] res);
        return {v, 1'b0, op, 8'h00, exc, dest, 32'hBFC0_0100, rt, res};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one instruction, then check MEM output during its first MEM cycle.
    task automatic run_load(input string tag, input logic [7:0] op, input logic [5:0] exc,
                            input logic [31:0] rt, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [31:0] exp_res);
        @(negedge clk);
        es         = mk_es(1'b1, op, exc, 7'd8, rt, addr);
        ws_allowin = 1'b1;
        @(negedge clk);
        es    = mk_es(1'b0, 8'h00, 6'd0, 7'd0, 32'd0, 32'd0);
        rdata = rd;
        #1;
        chk({tag, "_valid"}, 64'(msbus[94]), 64'd1);
        chk({tag, "_res"}, 64'(msbus[31:0]), 64'(exp_res));
    endtask

    initial begin
        rst_n      = 1'b0;
        es         = mk_es(1'b1, OP_ADD, 6'd0, 7'd3, 32'd0, 32'd5);
        ws_allowin = 1'b1;
        flushbus   = 33'd0;
        rdata      = 32'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_valid", 64'(msbus[94]), 64'd0);
            chk("rst_fwd_we", 64'(msfwd[37]), 64'd0);
            chk("rst_allowin", 64'(ms_allowin), 64'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        es = mk_es(1'b0, 8'h00, 6'd0, 7'd0, 32'd0, 32'd0);
        #1;
        chk("first_valid", 64'(msbus[94]), 64'd1);
        chk("first_res", 64'(msbus[31:0]), 64'h5);

        run_load("lb",  OP_LB,  6'd0, 32'd0, 32'h1000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
        run_load("lbu", OP_LBU, 6'd0, 32'd0, 32'h1000_0003, 32'h80FF_1234, 32'h0000_0080);
        run_load("lh",  OP_LH,  6'd0, 32'd0, 32'h1000_0002, 32'h80FF_1234, 32'hFFFF_80FF);
        run_load("lhu", OP_LHU, 6'd0, 32'd0, 32'h1000_0002, 32'h80FF_1234, 32'h0000_80FF);
        run_load("lwl", OP_LWL, 6'd0, 32'h1122_3344, 32'h1000_0001, 32'hAABB_CCDD, 32'hCCDD_3344);
        run_load("lwr", OP_LWR, 6'd0, 32'h1122_3344, 32'h1000_0002, 32'hAABB_CCDD, 32'h1122_AABB);
        run_load("lb_exc", OP_LB, 6'b000100, 32'd0, 32'h1000_0003, 32'h80FF_1234, 32'h1000_0003);
        chk("lb_exc_fwd_we", 64'(msfwd[37]), 64'd0);

        // Load stalled by WB for two cycles; SRAM data changes underneath.
        @(negedge clk);
        es         = mk_es(1'b1, OP_LW, 6'd0, 7'd9, 32'd0, 32'h1000_0000);
        ws_allowin = 1'b0;
        @(negedge clk);
        es    = mk_es(1'b0, 8'h00, 6'd0, 7'd0, 32'd0, 32'd0);
        rdata = 32'h1234_5678;
        #1;
        chk("stall1_allowin", 64'(ms_allowin), 64'd0);
        chk("stall1_res", 64'(msbus[31:0]), 64'h1234_5678);
        @(negedge clk);
        rdata = 32'hDEAD_BEEF;
        #1;
        chk("stall2_allowin", 64'(ms_allowin), 64'd0);
        chk("stall2_res", 64'(msbus[31:0]), 64'h1234_5678);
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        chk("release_res", 64'(msbus[31:0]), 64'h1234_5678);
        chk("release_valid", 64'(msbus[94]), 64'd1);
        chk("release_allowin", 64'(ms_allowin), 64'd1);

        // Flush while a load sits in MEM and EXE offers a new instruction.
        @(negedge clk);
        es = mk_es(1'b1, OP_LW, 6'd0, 7'd4, 32'd0, 32'h1000_0000);
        @(negedge clk);
        es       = mk_es(1'b1, OP_ADD, 6'd0, 7'd5, 32'd0, 32'h77);
        flushbus = {1'b1, 32'hBFC0_0380};
        #1;
        chk("flush_now_valid", 64'(msbus[94]), 64'd0);
        @(negedge clk);
        flushbus = 33'd0;
        es       = mk_es(1'b0, 8'h00, 6'd0, 7'd0, 32'd0, 32'd0);
        #1;
        chk("flush_next_valid", 64'(msbus[94]), 64'd0);
        chk("flush_next_fwd_we", 64'(msfwd[37]), 64'd0);

        // ALU result forwarding, with and without an exception.
        @(negedge clk);
        es = mk_es(1'b1, OP_ADD, 6'd0, 7'd3, 32'd0, 32'h5);
        @(negedge clk);
        es = mk_es(1'b1, OP_ADD, 6'b001000, 7'd3, 32'd0, 32'h5);
        #1;
        chk("add_fwd", 64'(msfwd), 64'({1'b1, 5'd3, 32'h5}));
        @(negedge clk);
        es = mk_es(1'b1, OP_ADD, 6'd0, 7'h23, 32'd0, 32'h9);
        #1;
        chk("add_exc_fwd_we", 64'(msfwd[37]), 64'd0);
        chk("add_exc_field", 64'(msbus[76:71]), 64'h08);
        chk("add_exc_valid", 64'(msbus[94]), 64'd1);
        @(negedge clk);
        es = mk_es(1'b0, 8'h00, 6'd0, 7'd0, 32'd0, 32'd0);
        #1;
        chk("cp0_dest_fwd_we", 64'(msfwd[37]), 64'd0);
        chk("cp0_dest_valid", 64'(msbus[94]), 64'd1);
        @(negedge clk);
        #1;
        chk("idle_valid", 64'(msbus[94]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vie_mem_stage.md
Name: vie_mem_stage

Overview:
- MEM pipeline stage between EXE and WB.
- Takes the EXE bus and the data-SRAM read data, which returns one cycle after EXE issues the access. Aligns and extends load data, including LWL/LWR merges, and emits the 95-bit msbus that WB decodes.
- Provides a forwarding bus to decode.
- Squashes its content on a WB flush.

Parameters:
- HOLD_EN, 1, when 1 a hold register captures SRAM read data while MEM is stalled by WB; when 0 the stage has no stall support.

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- esbus_i  in  127  EXE bus: [126] es_valid, [125] bd, [124:117] op, [116:109] cp0_addr, [108:103] exc, [102:96] dest, [95:64] pc, [63:32] rt_value, [31:0] res (ALU result or load/store address)
- ws_allowin  in  1  WB can accept
- flushbus_i  in  33  [32] flush_happen, [31:0] target (target unused here)
- data_sram_rdata  in  32  SRAM read data, valid in the first MEM cycle of a load
- ms_allowin  out  1  MEM can accept
- msbus_o  out  95  [94] valid, [93] bd, [92:85] op, [84:77] cp0_addr, [76:71] exc, [70:64] dest, [63:32] pc, [31:0] res
- msfwd_o  out  38  [37] we, [36:32] waddr, [31:0] wdata

Behaviour:
- Reset (reset==0 at edge): ms_valid_r=0, rdata_fresh=0, hold_vld=0. Resulting outputs:
  - msbus_o[94]=0
  - msfwd_o[37]=0
  - ms_allowin=1
  - Other msbus/msfwd payload bits undefined.
- Handshake:
  - ms_cango=1.
  - ms_allowin = !ms_valid_r || (ws_allowin && ms_cango).
  - Transfer from EXE when es_valid && ms_allowin; esbus_r latches esbus_i.
  - ms_valid_r: if ms_allowin, becomes es_valid && !flush_happen. Otherwise, flush_happen clears it and the previous value holds if no flush.
- msbus_o[94] = ms_valid_r && ms_cango && !flush_happen. Payload fields pass through from esbus_r, except res.
- Load data path:
  - rdata_fresh=1 on the cycle after a transfer, else 0.
  - ld_word = rdata_fresh ? data_sram_rdata : hold_r.
  - With HOLD_EN=1: when rdata_fresh && !ws_allowin, hold_r<=data_sram_rdata and hold_vld<=1. hold_vld clears on the next transfer or a flush.
- Load result by op; a = res[1:0]:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: halfword at a[1]*16, sign- or zero-extended. Misaligned halfwords are already flagged in exc by EXE; MEM does not re-check.
  - LW: ld_word.
  - LWL (little-endian): a=0 gives {ld[7:0],rt[23:0]}; a=1 gives {ld[15:0],rt[15:0]}; a=2 gives {ld[23:0],rt[7:0]}; a=3 gives ld.
  - LWR: a=0 gives ld; a=1 gives {rt[31:24],ld[31:8]}; a=2 gives {rt[31:16],ld[31:16]}; a=3 gives {rt[31:8],ld[31:24]}.
  - All other ops: res unchanged.
  - If exc!=0: res passes the raw address unchanged and no load merge is applied.
- Forwarding:
  - msfwd we = ms_valid_r && dest[6:5]==2'b00 && exc==0.
  - waddr = dest[4:0]; wdata = final res.
  - MFC0 data is not forwarded (WB produces it); decode stalls on MFC0 in MEM using op.
- Simultaneous events:
  - flush_happen wins over a same-cycle transfer.
  - A stall with fresh data captures data into hold_r, and is also killed by the flush.
  - Reset overrides all.
- Reset mid-stall discards hold_r contents (hold_vld=0).

Decomposition:
- Shared header (existing defines file) holds:
  - Vesbus=127, Vmsbus=95, Vmsfwd=38, Vflushbus=33
  - VIE_OP_LB/LBU/LH/LHU/LW/LWL/LWR opcode constants, alongside the existing MFC0/MTC0/ERET.
- One natural sub-module: vie_load_align, purely combinational (op, addr[1:0], ld_word, rt_value → result). It is unit-tested separately.

Test Plan:
- Reset held low 3 cycles with es_valid=1 → msbus_o[94]=0, msfwd_o[37]=0, ms_allowin=1; after release, first transfer appears in msbus 1 cycle later.
- LB at addr 0x...03, rdata=0x80FF_1234 → res=0xFFFF_FF80; LBU same → 0x0000_0080; LH addr 0x...02 → 0xFFFF_80FF; LHU → 0x0000_80FF.
- LWL a=1, rdata=0xAABBCCDD, rt=0x11223344 → 0xCCDD3344; LWR a=2 same inputs → 0x1122AABB.
- LW with ws_allowin=0 for 2 cycles after transfer, rdata changes to 0xDEADBEEF after the first cycle (original 0x12345678) → when ws_allowin rises, res=0x12345678 and ms_allowin=0 during the stall.
- flush_happen=1 while a valid load sits in MEM with a new EXE transfer same cycle → next cycle msbus_o[94]=0, msfwd we=0.
- ADD result 0x5 dest=3, exc=0 → msfwd_o={1,5'd3,32'h5}. With exc=6'b001000 → we=0, msbus exc field=0x08, valid=1.
